// File: rtl/component_counter.sv
// Counts connected components of the set bits in a 128-node graph whose nodes are the 7-bit
// indices 0..127. Nodes i and j are adjacent when they differ in exactly one bit (7-cube).
// Each component is flood-filled one hop per cycle from a seed node.
//
// Build option: define SINGLETON_SKIP_EN to retire all isolated nodes in a single SEED cycle
// instead of spending a SEED+GROW pair on each one. The result is unchanged; only latency drops.
module component_counter #(
    parameter int unsigned COUNT_WIDTH = 7,
    parameter bit          SEED_HIGH   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [127:0]           graphIn,
    input  logic                   graphInValid,
    output logic                   graphInReady,
    output logic [COUNT_WIDTH-1:0] componentCount,
    output logic                   countValid,
    input  logic                   countReady,
    output logic                   busy
);

    localparam int unsigned MaxCount = (32'd1 << COUNT_WIDTH) - 32'd1;

    // Bit i set where bit d of index i is 0, one mask per cube dimension.
    localparam logic [6:0][127:0] DimLo = {
        {64'h0, {64{1'b1}}},
        {2{64'h0000_0000_FFFF_FFFF}},
        {4{32'h0000_FFFF}},
        {8{16'h00FF}},
        {16{8'h0F}},
        {16{8'h33}},
        {16{8'h55}}
    };

    typedef enum logic [1:0] {
        StIdle,
        StSeed,
        StGrow,
        StEmit
    } state_e;

    state_e                   state_q, state_d;
    logic [127:0]             remaining_q, remaining_d;
    logic [127:0]             frontier_q, frontier_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [COUNT_WIDTH-1:0]   count_out_q;

    logic [127:0]             nbr;
    logic [127:0]             new_nodes;
    logic [6:0]               seed_idx;
    logic [127:0]             seed_onehot;

    // Union of all single-bit-flip neighbours of the nodes in f.
    function automatic logic [127:0] neighbours(input logic [127:0] f);
        logic [127:0] n;
        n = '0;
        for (int d = 0; d < 7; d++) begin
            n = n | ((f & DimLo[d]) << (1 << d)) | ((f & ~DimLo[d]) >> (1 << d));
        end
        return n;
    endfunction

    // Lowest (or highest, with SEED_HIGH) set index; only used when r is non-zero.
    function automatic logic [6:0] pick_seed(input logic [127:0] r);
        logic [6:0] s;
        logic       found;
        s     = '0;
        found = 1'b0;
        for (int i = 0; i < 128; i++) begin
            if (r[i]) begin
                if (SEED_HIGH || !found) begin
                    s = 7'(i);
                end
                found = 1'b1;
            end
        end
        return s;
    endfunction

    // Saturating add, clamped at all-ones of the count width.
    function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                       input logic [7:0] b);
        int unsigned s;
        s = 32'(a) + 32'(b);
        if (s > MaxCount) begin
            s = MaxCount;
        end
        return s[COUNT_WIDTH-1:0];
    endfunction

`ifdef SINGLETON_SKIP_EN
    function automatic logic [7:0] popcount(input logic [127:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 128; i++) begin
            c = c + 8'(v[i]);
        end
        return c;
    endfunction

    logic [127:0] isolated;
`endif

    // Next-state logic for the flood-fill walk.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        frontier_d  = frontier_q;
        count_d     = count_q;

        nbr         = neighbours(frontier_q);
        new_nodes   = nbr & remaining_q;
        seed_idx    = pick_seed(remaining_q);
        seed_onehot = 128'd1 << seed_idx;
`ifdef SINGLETON_SKIP_EN
        isolated    = remaining_q & ~neighbours(remaining_q);
`endif

        unique case (state_q)
            StIdle: begin
                if (graphInValid) begin
                    remaining_d = graphIn;
                    count_d     = '0;
                    state_d     = StSeed;
                end
            end
            StSeed: begin
                if (remaining_q == '0) begin
                    state_d = StEmit;
`ifdef SINGLETON_SKIP_EN
                end else if (isolated != '0) begin
                    // Each isolated node is its own component; retire them all at once.
                    count_d     = sat_add(count_q, popcount(isolated));
                    remaining_d = remaining_q & ~isolated;
`endif
                end else begin
                    frontier_d  = seed_onehot;
                    remaining_d = remaining_q & ~seed_onehot;
                    state_d     = StGrow;
                end
            end
            StGrow: begin
                remaining_d = remaining_q & ~new_nodes;
                frontier_d  = new_nodes;
                if (new_nodes == '0) begin
                    count_d = sat_add(count_q, 8'd1);
                    state_d = StSeed;
                end
            end
            StEmit: begin
                if (countReady) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and working registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            frontier_q  <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            frontier_q  <= frontier_d;
            count_q     <= count_d;
        end
    end

    // Result register, loaded only on entry to EMIT so it stays stable during the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out_q <= '0;
        end else if (state_q != StEmit && state_d == StEmit) begin
            count_out_q <= count_q;
        end
    end

    // Handshake outputs.
    always_comb begin
        graphInReady   = (state_q == StIdle) && !rst;
        countValid     = (state_q == StEmit);
        busy           = (state_q != StIdle);
        componentCount = count_out_q;
    end

endmodule

// File: tb/tb_component_counter.sv
// Directed self-checking bench for component_counter (default and 5-bit count instances).
module tb_component_counter;

    logic         clk;
    logic         rst;
    logic [127:0] graphIn;
    logic         graphInValid;
    logic         countReady;

    logic         graphInReady;
    logic [6:0]   componentCount;
    logic         countValid;
    logic         busy;

    logic         n_graphInReady;
    logic [4:0]   n_componentCount;
    logic         n_countValid;
    logic         n_busy;

    int total;
    int bad;

    component_counter dut (
        .clk            (clk),
        .rst            (rst),
        .graphIn        (graphIn),
        .graphInValid   (graphInValid),
        .graphInReady   (graphInReady),
        .componentCount (componentCount),
        .countValid     (countValid),
        .countReady     (countReady),
        .busy           (busy)
    );

    component_counter #(.COUNT_WIDTH(5)) dut_narrow (
        .clk            (clk),
        .rst            (rst),
        .graphIn        (graphIn),
        .graphInValid   (graphInValid),
        .graphInReady   (n_graphInReady),
        .componentCount (n_componentCount),
        .countValid     (n_countValid),
        .countReady     (countReady),
        .busy           (n_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SINGLETON_SKIP_EN
    localparam int LatDist2 = 2;
    localparam int LatEven  = 2;
`else
    localparam int LatDist2 = 9;
    localparam int LatEven  = 129;
`endif

    // Present g until accepted; returns with inputs idle, #1 after the accept edge.
    task automatic send(input logic [127:0] g);
        int guard;
        guard = 0;
        while (!graphInReady && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        graphIn      = g;
        graphInValid = 1'b1;
        @(posedge clk);
        #1;
        graphInValid = 1'b0;
    endtask

    // Cycles from accept edge until countValid is seen; -1 on timeout.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!countValid && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!countValid) cyc = -1;
    endtask

    task automatic handshake();
        countReady = 1'b1;
        @(posedge clk);
        #1;
        countReady = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (graphInReady !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b want=0", graphInReady);
        end
        total++;
        if (countValid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b want=0", countValid);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        total++;
        if (componentCount !== 7'd0) begin
            bad++; $display("FAIL reset_count got=%0d want=0", componentCount);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (graphInReady !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready got=%b want=1", graphInReady);
        end
    endtask

    task automatic test_empty();
        int cyc;
        send(128'd0);
        wait_valid(cyc);
        total++;
        if (cyc !== 1) begin
            bad++; $display("FAIL empty_latency got=%0d want=1", cyc);
        end
        total++;
        if (componentCount !== 7'd0) begin
            bad++; $display("FAIL empty_count got=%0d want=0", componentCount);
        end
        handshake();
        total++;
        if (countValid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL empty_release got=%b%b want=00", countValid, busy);
        end
    endtask

    task automatic test_chain();
        int cyc;
        logic [127:0] g;
        g = '0;
        g[0] = 1'b1; g[1] = 1'b1; g[3] = 1'b1; g[7] = 1'b1;
        send(g);
        total++;
        if (busy !== 1'b1 || graphInReady !== 1'b0) begin
            bad++; $display("FAIL chain_busy got=%b%b want=10", busy, graphInReady);
        end
        wait_valid(cyc);
        total++;
        if (cyc !== 6) begin
            bad++; $display("FAIL chain_latency got=%0d want=6", cyc);
        end
        total++;
        if (componentCount !== 7'd1) begin
            bad++; $display("FAIL chain_count got=%0d want=1", componentCount);
        end
        handshake();
    endtask

    task automatic test_distance_two();
        int cyc;
        logic [127:0] g;
        g = '0;
        g[0] = 1'b1; g[3] = 1'b1; g[5] = 1'b1; g[6] = 1'b1;
        send(g);
        wait_valid(cyc);
        total++;
        if (cyc !== LatDist2) begin
            bad++; $display("FAIL dist2_latency got=%0d want=%0d", cyc, LatDist2);
        end
        total++;
        if (componentCount !== 7'd4) begin
            bad++; $display("FAIL dist2_count got=%0d want=4", componentCount);
        end
        handshake();
    endtask

    task automatic test_full();
        int cyc;
        send({128{1'b1}});
        wait_valid(cyc);
        total++;
        if (cyc !== 10) begin
            bad++; $display("FAIL full_latency got=%0d want=10", cyc);
        end
        total++;
        if (componentCount !== 7'd1) begin
            bad++; $display("FAIL full_count got=%0d want=1", componentCount);
        end
        handshake();
    endtask

    task automatic test_even_parity();
        int cyc;
        logic [127:0] g;
        logic [6:0] idx;
        for (int i = 0; i < 128; i++) begin
            idx  = 7'(i);
            g[i] = ~(^idx);
        end
        send(g);
        wait_valid(cyc);
        total++;
        if (cyc !== LatEven) begin
            bad++; $display("FAIL even_latency got=%0d want=%0d", cyc, LatEven);
        end
        total++;
        if (componentCount !== 7'd64) begin
            bad++; $display("FAIL even_count got=%0d want=64", componentCount);
        end
        total++;
        if (n_countValid !== 1'b1 || n_componentCount !== 5'd31) begin
            bad++; $display("FAIL even_count_narrow got=%b/%0d want=1/31", n_countValid,
                            n_componentCount);
        end
        handshake();
    endtask

    task automatic test_hold_in_emit();
        int cyc;
        logic [127:0] g;
        g = '0;
        g[0] = 1'b1; g[1] = 1'b1; g[3] = 1'b1; g[7] = 1'b1;
        send(g);
        wait_valid(cyc);
        graphIn      = {128{1'b1}};
        graphInValid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (componentCount !== 7'd1 || countValid !== 1'b1 || graphInReady !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d got=%0d/%b/%b want=1/1/0", k, componentCount,
                         countValid, graphInReady);
            end
        end
        graphInValid = 1'b0;
        handshake();
        total++;
        if (countValid !== 1'b0 || busy !== 1'b0 || graphInReady !== 1'b1) begin
            bad++; $display("FAIL hold_release got=%b%b%b want=001", countValid, busy,
                            graphInReady);
        end
    endtask

    task automatic test_back_to_back();
        countReady = 1'b1;
        send(128'd0);
        total++;
        if (countValid !== 1'b0) begin
            bad++; $display("FAIL b2b_seed_valid got=%b want=0", countValid);
        end
        @(posedge clk);
        #1;
        total++;
        if (countValid !== 1'b1) begin
            bad++; $display("FAIL b2b_rise got=%b want=1", countValid);
        end
        @(posedge clk);
        #1;
        total++;
        if (countValid !== 1'b0 || graphInReady !== 1'b1) begin
            bad++; $display("FAIL b2b_done got=%b%b want=01", countValid, graphInReady);
        end
        countReady = 1'b0;
    endtask

    task automatic test_reset_mid_grow();
        logic [127:0] g;
        g = '0;
        g[0] = 1'b1; g[1] = 1'b1;
        // Leave a non-zero result in the output register first.
        send(g);
        repeat (6) @(posedge clk);
        #1;
        handshake();
        send({128{1'b1}});
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL midrst_busy_before got=%b want=1", busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if (countValid !== 1'b0 || busy !== 1'b0 || graphInReady !== 1'b0) begin
            bad++; $display("FAIL midrst_asserted got=%b%b%b want=000", countValid, busy,
                            graphInReady);
        end
        total++;
        if (componentCount !== 7'd0) begin
            bad++; $display("FAIL midrst_count got=%0d want=0", componentCount);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (countValid !== 1'b0 || busy !== 1'b0 || graphInReady !== 1'b1) begin
            bad++; $display("FAIL midrst_release got=%b%b%b want=001", countValid, busy,
                            graphInReady);
        end
    endtask

    task automatic test_after_reset();
        int cyc;
        logic [127:0] g;
        g = '0;
        g[0] = 1'b1; g[3] = 1'b1; g[5] = 1'b1; g[6] = 1'b1;
        @(posedge clk);
        #1;
        send(g);
        wait_valid(cyc);
        total++;
        if (cyc !== LatDist2 || componentCount !== 7'd4) begin
            bad++; $display("FAIL after_reset got=%0d/%0d want=%0d/4", cyc, componentCount,
                            LatDist2);
        end
        handshake();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        graphIn      = '0;
        graphInValid = 1'b0;
        countReady   = 1'b0;
        test_reset();
        test_empty();
        test_chain();
        test_distance_two();
        test_full();
        test_even_parity();
        test_hold_in_emit();
        test_back_to_back();
        test_reset_mid_grow();
        test_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
